fp_add_sequencer: RTL and testbench

Multi-cycle controller and datapath for single-precision floating-point add/subtract in the RISC execute stage. It accepts two IEEE-754 operands over a valid/ready handshake and steps them through fixed ALIGN, ADD, NORM and PACK states. In NORM it produces the 6-bit sign-magnitude exponent-adjust code and zero flag. In PACK it applies that code to the exponent and delivers a packed result with status flags.

---
 rtl/fp_add_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_add_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single-precision add/subtract stepping ALIGN/ADD/NORM/PACK.
// Define FPADD_ROUND_NEAREST_EN for round-to-nearest-even at PACK; otherwise the result is truncated.
module fp_add_sequencer #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned GRS_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_zero,
    output logic                   out_overflow,
    output logic                   busy
);
    localparam int unsigned MW    = MAN_W + 1 + GRS_W;
    localparam int unsigned SW    = MW + 1;
    localparam int unsigned LZ_W  = $clog2(MW + 1);
    localparam int unsigned ADJ_W = LZ_W + 1;
    // One bit wider than the biased range so a round carry and an underflow cannot alias.
    localparam int unsigned XW    = EXP_W + 2;
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [XW-1:0]  EXP_TOP  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0]  EXP_ZERO = '0;
    localparam logic [EXP_W+MAN_W:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE} state_t;

    state_t state_q, state_d;

    logic               op_a_sign, op_b_sign, nan_q;
    logic [EXP_W-1:0]   op_a_exp, op_b_exp;
    logic [MAN_W-1:0]   op_a_frac, op_b_frac;
    logic               big_sign_q, small_sign_q, negz_q;
    logic [EXP_W-1:0]   exp_q;
    logic [MW-1:0]      big_man_q, small_man_q;
    logic [SW-1:0]      sum_q;
    logic               sign_q, zero_q;
    logic [MW-1:0]      norm_q;
    logic [ADJ_W-1:0]   adj_q;

    // State register and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == S_IDLE);
            busy      <= (state_d != S_IDLE);
            out_valid <= (state_q == S_DONE) && !(out_valid && out_ready);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid && in_ready) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_PACK;
            S_PACK:  state_d = S_DONE;
            S_DONE:  if (out_valid && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALIGN: flush denormals, order by magnitude, shift the smaller operand with sticky
    logic             a_zero, b_zero, swap, negz_d;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic [EXP_W-1:0] big_exp, small_exp, diff;
    logic             big_sign, small_sign;
    logic [MW-1:0]    big_man, small_man, small_sh, shift_mask;

    always_comb begin
        a_zero     = (op_a_exp == '0);
        b_zero     = (op_b_exp == '0);
        a_frac     = a_zero ? '0 : op_a_frac;
        b_frac     = b_zero ? '0 : op_b_frac;
        negz_d     = a_zero && b_zero && op_a_sign && op_b_sign;
        swap       = {op_b_exp, b_frac} > {op_a_exp, a_frac};
        big_exp    = swap ? op_b_exp  : op_a_exp;
        small_exp  = swap ? op_a_exp  : op_b_exp;
        big_sign   = swap ? op_b_sign : op_a_sign;
        small_sign = swap ? op_a_sign : op_b_sign;
        big_man    = swap ? {~b_zero, b_frac, {GRS_W{1'b0}}} : {~a_zero, a_frac, {GRS_W{1'b0}}};
        small_man  = swap ? {~a_zero, a_frac, {GRS_W{1'b0}}} : {~b_zero, b_frac, {GRS_W{1'b0}}};
        diff       = big_exp - small_exp;
        shift_mask = '0;
        if (diff >= EXP_W'(MW)) begin
            small_sh = {{(MW-1){1'b0}}, |small_man};
        end else begin
            shift_mask = (MW'(1) << diff) - MW'(1);
            small_sh   = (small_man >> diff) | {{(MW-1){1'b0}}, |(small_man & shift_mask)};
        end
    end

    // NORM: single right shift on carry, otherwise left shift by leading-zero count
    logic [LZ_W-1:0]  lz;
    logic [MW-1:0]    norm_d;
    logic [ADJ_W-1:0] adj_d;
    logic             zero_d, norm_sign;

    always_comb begin
        lz = LZ_W'(MW);
        for (int unsigned i = 0; i < MW; i++) begin
            if (sum_q[i]) lz = LZ_W'(MW - 1 - i);
        end
        if (sum_q[SW-1]) begin
            norm_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            adj_d  = ADJ_W'(1);
        end else begin
            norm_d = sum_q[MW-1:0] << lz;
            adj_d  = {1'b1, lz};
        end
        zero_d    = (sum_q == '0);
        norm_sign = zero_d ? negz_q : sign_q;
    end

    // PACK: apply exponent adjust, optional rounding, then classify the result
    logic signed [XW-1:0]  exp_x;
    logic [MAN_W-1:0]      frac;
    logic [EXP_W+MAN_W:0]  res_d;
    logic                  res_zero_d, res_ovf_d;
`ifdef FPADD_ROUND_NEAREST_EN
    logic                  round_up;
    logic [MAN_W+1:0]      mant_r;
`endif

    always_comb begin
        exp_x = XW'(exp_q);
        if (adj_q[ADJ_W-1]) exp_x = exp_x - XW'(adj_q[LZ_W-1:0]);
        else                exp_x = exp_x + XW'(adj_q[LZ_W-1:0]);
`ifdef FPADD_ROUND_NEAREST_EN
        round_up = norm_q[GRS_W-1] & ((|norm_q[GRS_W-2:0]) | norm_q[GRS_W]);
        mant_r   = (MAN_W+2)'({1'b0, norm_q[MW-1:GRS_W]}) + (MAN_W+2)'(round_up);
        frac     = MAN_W'(mant_r);
        if (mant_r[MAN_W+1]) exp_x = exp_x + XW'(1);
`else
        frac = MAN_W'(norm_q >> GRS_W);
`endif
        res_d      = {sign_q, exp_x[EXP_W-1:0], frac};
        res_zero_d = 1'b0;
        res_ovf_d  = 1'b0;
        if (nan_q) begin
            res_d = QNAN;
        end else if (zero_q) begin
            res_d      = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            res_zero_d = 1'b1;
        end else if (exp_x >= EXP_TOP) begin
            res_d     = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
            res_ovf_d = 1'b1;
        end else if (exp_x <= EXP_ZERO) begin
            res_d      = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            res_zero_d = 1'b1;
        end
    end

    // Datapath stage registers, each loaded in its own state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_sign    <= 1'b0;
            op_b_sign    <= 1'b0;
            op_a_exp     <= '0;
            op_b_exp     <= '0;
            op_a_frac    <= '0;
            op_b_frac    <= '0;
            nan_q        <= 1'b0;
            big_sign_q   <= 1'b0;
            small_sign_q <= 1'b0;
            negz_q       <= 1'b0;
            exp_q        <= '0;
            big_man_q    <= '0;
            small_man_q  <= '0;
            sum_q        <= '0;
            sign_q       <= 1'b0;
            zero_q       <= 1'b0;
            norm_q       <= '0;
            adj_q        <= '0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid && in_ready) begin
                    {op_a_sign, op_a_exp, op_a_frac} <= in_a;
                    {op_b_sign, op_b_exp, op_b_frac} <= {in_b[EXP_W+MAN_W] ^ in_sub, in_b[EXP_W+MAN_W-1:0]};
                    nan_q <= (in_a[EXP_W+MAN_W-1:MAN_W] == EXP_ONES) ||
                             (in_b[EXP_W+MAN_W-1:MAN_W] == EXP_ONES);
                end
                S_ALIGN: begin
                    big_sign_q   <= big_sign;
                    small_sign_q <= small_sign;
                    negz_q       <= negz_d;
                    exp_q        <= big_exp;
                    big_man_q    <= big_man;
                    small_man_q  <= small_sh;
                end
                S_ADD: begin
                    sign_q <= big_sign_q;
                    if (big_sign_q == small_sign_q) sum_q <= {1'b0, big_man_q} + {1'b0, small_man_q};
                    else                            sum_q <= {1'b0, big_man_q} - {1'b0, small_man_q};
                end
                S_NORM: begin
                    norm_q <= norm_d;
                    adj_q  <= adj_d;
                    zero_q <= zero_d;
                    sign_q <= norm_sign;
                end
                S_PACK: begin
                    out_result   <= res_d;
                    out_zero     <= res_zero_d;
                    out_overflow <= res_ovf_d;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer: hand-computed vectors, latency, backpressure and mid-op reset.
module tb_fp_add_sequencer;
    logic        clk, rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zero, out_overflow, busy;

    int total = 0;
    int bad   = 0;
    int lat;
    int seen;

    fp_add_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_overflow(out_overflow), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns cycles from the previous edge until out_valid, 0 if it never rises.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 12 && cycles == 0; k++) begin
            @(posedge clk); #1;
            if (out_valid) cycles = k;
        end
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic sub);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [31:0] er, input logic ez, input logic eo);
        int l;
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        accept(a, b, sub);
        wait_valid(l);
        check({tag, ".latency"}, 32'(l), 32'd5);
        check({tag, ".result"}, out_result, er);
        check({tag, ".zero"}, 32'(out_zero), 32'(ez));
        check({tag, ".ovf"}, 32'(out_overflow), 32'(eo));
        take(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", out_result, 32'h0);
        check("rst.zero", 32'(out_zero), 32'd0);
        check("rst.ovf", 32'(out_overflow), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("add_1p1",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        do_op("cancel",    32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        do_op("lnorm",     32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 1'b0, 1'b0);
        check("lnorm.adjust", 32'(dut.adj_q), 32'h22);
        do_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1);
        do_op("nan",       32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
        do_op("denorm",    32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        do_op("neg_res",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
        do_op("negzero",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b0);
        do_op("mixzero",   32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        do_op("underflow", 32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 1'b1, 1'b0);
`ifdef FPADD_ROUND_NEAREST_EN
        do_op("round",     32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0);
`else
        do_op("round",     32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
`endif

        // Backpressure: result held while a new operand pair waits on in_valid
        accept(32'h40000000, 32'h3F800000, 1'b0);
        wait_valid(lat);
        check("bp.latency", 32'(lat), 32'd5);
        in_a = 32'h40400000; in_b = 32'h3F800000; in_sub = 1'b0; in_valid = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_result", out_result, 32'h40400000);
            check("bp.hold_ready", 32'(in_ready), 32'd0);
            check("bp.hold_busy", 32'(busy), 32'd1);
        end
        take("bp");
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.held_accepted", 32'(busy), 32'd1);
        wait_valid(lat);
        check("bp.held_latency", 32'(lat), 32'd5);
        check("bp.held_result", out_result, 32'h40800000);
        take("bp_held");

        // Reset while the operation is in NORM discards it
        accept(32'h3F800000, 32'h3F800000, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mrst.busy", 32'(busy), 32'd0);
        check("mrst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("mrst.no_output", 32'(seen), 32'd0);
        check("mrst.result", out_result, 32'h0);

        do_op("post_rst",  32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
